pic_cmd_sequencer: RTL
======================

# pic_cmd_sequencer

Clocked, parametrised command sequencer for the 8259-style interrupt controller: it sits between the data bus buffer and the control logic. It synchronises the CPU strobes and runs the full ICW1→ICW2→[ICW3]→[ICW4] initialisation state machine, honouring the SNGL and IC4 bits. After initialisation it decodes OCW1–OCW3, keeps the mask and read-select registers, and drives the CPU read mux. Decoded commands reach the control logic through a small valid/ready FIFO, so no command is lost while that logic is busy.

## Interface
- SYNC_STAGES, 2: synchroniser flops on cs_n, rd_n, wr_n, a0 and cpu_din (≥1).
- FIFO_DEPTH, 2: command FIFO entries (power of two, ≥2).
- RESET_IMR, 8'h00: IMR value after reset and after each ICW1.
- clk  in  1  single system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cs_n, rd_n, wr_n, a0  in  1 each  raw CPU strobes and address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  read data.
- cpu_doe  out  1  read-drive enable.
- irr_in, isr_in  in  8 each  status from the priority logic.
- cmd_valid  out  1  FIFO head valid.
- cmd_ready  in  1  control logic accepts the head.
- cmd_type  out  1  1 = ICW, 0 = OCW.
- cmd_nr  out  2  word index (ICW1–4 → 0–3; OCW1/2/3 → 0/1/2).
- cmd_data  out  8  command byte.
- init_done  out  1  initialisation complete.
- imr  out  8  mask from OCW1.
- icw1_q, icw2_q, icw3_q, icw4_q  out  8 each  stored ICWs.
- seq_err  out  1  one-cycle pulse: out-of-sequence write ignored.
- fifo_ovf  out  1  one-cycle pulse: command dropped because the FIFO was full.

## Operation
- **Synchronisation.** All of cs_n, rd_n, wr_n, a0 and cpu_din pass through the same SYNC_STAGES delay so they stay aligned. A write event (W) is a 0→1 transition of the synchronised wr_n while the synchronised cs_n is 0. a0 and data are taken from the same synchronised stage.
- **States.** WAIT_ICW1 (reset state), WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- **ICW1** is W with a0=0 and d[4]=1, accepted in any state:
  - stores icw1_q and clears icw3_q and icw4_q;
  - sets imr to RESET_IMR and the read-select register ris to 0;
  - drops init_done to 0 and goes to WAIT_ICW2.
- **WAIT_ICW2.** W with a0=1 → icw2_q. Next state: WAIT_ICW3 if icw1_q[1]=0; otherwise WAIT_ICW4 if icw1_q[0]=1; otherwise READY.
- **WAIT_ICW3.** W with a0=1 → icw3_q. Next state: WAIT_ICW4 if icw1_q[0]=1, else READY.
- **WAIT_ICW4.** W with a0=1 → icw4_q, then READY.
- **Illegal writes.** In any WAIT_ICW2–4 state, W with a0=0 and d[4]=0 is ignored: seq_err pulses and the state is held. In WAIT_ICW1, any W that is not ICW1 is ignored and seq_err pulses.
- **READY.** init_done=1.
  - W with a0=1 is OCW1: imr ← d.
  - W with a0=0 and d[4:3]=00 is OCW2: no local register.
  - W with a0=0 and d[4:3]=01 is OCW3: if d[1]=1 then ris ← d[0].
- **FIFO push.** Every accepted ICW or OCW pushes {type, nr, data} into the FIFO.
- **FIFO behaviour.**
  - cmd_valid = FIFO not empty; the head is popped when cmd_valid and cmd_ready are both 1.
  - A push into a full FIFO is dropped and fifo_ovf pulses; the register and state updates still occur.
  - A push and a pop on the same edge when the FIFO is full both succeed.
  - Entries wrap modulo FIFO_DEPTH.
- **Read mux.**
  - When the synchronised cs_n=0 and rd_n=0 (and wr_n=1): cpu_doe=1 and cpu_dout = a0 ? imr : (ris ? isr_in : irr_in).
  - Otherwise cpu_doe=0 and cpu_dout=0.
  - rd_n and wr_n both low counts as no read; the write still commits on the wr_n rise.

## Timing
- **Reset values.** All outputs are 0 except imr=RESET_IMR. State = WAIT_ICW1, FIFO empty, ris=0. Reset asserted mid-sequence or mid-transfer aborts immediately and flushes the FIFO.
- **Write latency.** Pin wr_n rise → W detected after SYNC_STAGES+1 clk edges. State, ICW/imr registers, seq_err/fifo_ovf and the FIFO push all update on that edge. cmd_valid is high from that edge onward if the FIFO was empty.
- **Read latency.** Pin rd_n fall → cpu_doe high after SYNC_STAGES+1 edges. cpu_dout is registered and follows irr_in/isr_in with one cycle of lag.
- **Minimum write spacing.** Back-to-back writes need wr_n high for ≥ SYNC_STAGES+1 clk periods.
- **Handshake.** Once cmd_valid is high, cmd_type, cmd_nr and cmd_data are stable until popped.

## Test plan
- **Single mode, no ICW4.** After reset, write a0=0 0x12 then a0=1 0x20. Required: FIFO yields (1,0,0x12), (1,1,0x20); init_done=1; icw3_q=0; no seq_err.
- **Cascade with ICW4.** Write a0=0 0x11, a0=1 0x08, a0=1 0x04, a0=1 0x01. Required: four ICW entries with nr 0–3, then READY; an OCW1 write of 0xF0 then gives imr=0xF0 and FIFO entry (0,0,0xF0).
- **OCW3 read select.** In READY, write OCW3 0x0B, then read with a0=0 while isr_in=0x40 and irr_in=0x81. Required: cpu_dout=0x40. After OCW3 0x0A, the same read returns 0x81. A read with a0=1 returns imr.
- **Out-of-sequence writes.** Write OCW2 0x20 in WAIT_ICW1. Required: seq_err pulse, no push. In WAIT_ICW2, write a0=0 0x20. Required: seq_err pulse, state held.
- **Backpressure and overflow.** Hold cmd_ready=0 and issue three OCW1 writes with FIFO_DEPTH=2. Required: two entries kept, fifo_ovf pulses on the third, and imr equals the third byte.
- **Re-initialisation and reset.** Issue ICW1 while in READY with imr=0xFF. Required: imr=RESET_IMR and init_done=0. Asserting rst_n mid-ICW3 returns the block to WAIT_ICW1 with the FIFO empty.

Source files
------------

// File: rtl/pic_cmd_sequencer.sv
// pic_cmd_sequencer: CPU strobe synchroniser, ICW/OCW command state machine,
// mask/read-select registers, CPU read mux and command FIFO for an 8259-style PIC.
module pic_cmd_sequencer #(
    parameter int         SYNC_STAGES = 2,
    parameter int         FIFO_DEPTH  = 2,
    parameter logic [7:0] RESET_IMR   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       cpu_doe,
    input  logic [7:0] irr_in,
    input  logic [7:0] isr_in,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_type,
    output logic [1:0] cmd_nr,
    output logic [7:0] cmd_data,
    output logic       init_done,
    output logic [7:0] imr,
    output logic [7:0] icw1_q,
    output logic [7:0] icw2_q,
    output logic [7:0] icw3_q,
    output logic [7:0] icw4_q,
    output logic       seq_err,
    output logic       fifo_ovf
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        WAIT_ICW1,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    // Bus bundle {cs_n, rd_n, wr_n, a0, din}; idle value has all strobes high.
    localparam logic [11:0] BUS_IDLE = 12'hE00;

    logic [11:0] sync_q [SYNC_STAGES];
    logic        wr_prev;
    logic        s_cs_n, s_rd_n, s_wr_n, s_a0;
    logic [7:0]  s_din;
    logic        wr_event;
    logic        is_icw1;

    state_t      state_q, state_d;
    logic        accept;
    logic        err_d;
    logic        push_type;
    logic [1:0]  push_nr;
    logic        ld_icw1, ld_icw2, ld_icw3, ld_icw4, ld_imr, ld_ris;
    logic        ris;

    logic [10:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        pop, push_ok, ovf_d;
    logic        doe_d;

    // Delay every CPU-side input through the same chain so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= BUS_IDLE;
            end
            wr_prev <= 1'b1;
        end else begin
            sync_q[0] <= {cs_n, rd_n, wr_n, a0, cpu_din};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            wr_prev <= sync_q[SYNC_STAGES-1][9];
        end
    end

    assign s_cs_n   = sync_q[SYNC_STAGES-1][11];
    assign s_rd_n   = sync_q[SYNC_STAGES-1][10];
    assign s_wr_n   = sync_q[SYNC_STAGES-1][9];
    assign s_a0     = sync_q[SYNC_STAGES-1][8];
    assign s_din    = sync_q[SYNC_STAGES-1][7:0];
    assign wr_event = s_wr_n & ~wr_prev & ~s_cs_n;
    assign is_icw1  = ~s_a0 & s_din[4];

    // Command state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_ICW1;
        end else begin
            state_q <= state_d;
        end
    end

    // Decode each write against the current state: next state, register loads, FIFO entry.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        err_d     = 1'b0;
        push_type = 1'b0;
        push_nr   = 2'd0;
        ld_icw1   = 1'b0;
        ld_icw2   = 1'b0;
        ld_icw3   = 1'b0;
        ld_icw4   = 1'b0;
        ld_imr    = 1'b0;
        ld_ris    = 1'b0;
        if (wr_event) begin
            if (is_icw1) begin
                accept    = 1'b1;
                push_type = 1'b1;
                push_nr   = 2'd0;
                ld_icw1   = 1'b1;
                state_d   = WAIT_ICW2;
            end else begin
                case (state_q)
                    WAIT_ICW1: err_d = 1'b1;
                    WAIT_ICW2: begin
                        if (s_a0) begin
                            accept    = 1'b1;
                            push_type = 1'b1;
                            push_nr   = 2'd1;
                            ld_icw2   = 1'b1;
                            if (!icw1_q[1])     state_d = WAIT_ICW3;
                            else if (icw1_q[0]) state_d = WAIT_ICW4;
                            else                state_d = READY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    WAIT_ICW3: begin
                        if (s_a0) begin
                            accept    = 1'b1;
                            push_type = 1'b1;
                            push_nr   = 2'd2;
                            ld_icw3   = 1'b1;
                            state_d   = icw1_q[0] ? WAIT_ICW4 : READY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    WAIT_ICW4: begin
                        if (s_a0) begin
                            accept    = 1'b1;
                            push_type = 1'b1;
                            push_nr   = 2'd3;
                            ld_icw4   = 1'b1;
                            state_d   = READY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    READY: begin
                        accept = 1'b1;
                        if (s_a0) begin
                            push_nr = 2'd0;
                            ld_imr  = 1'b1;
                        end else if (!s_din[3]) begin
                            push_nr = 2'd1;
                        end else begin
                            push_nr = 2'd2;
                            ld_ris  = s_din[1];
                        end
                    end
                    default: state_d = WAIT_ICW1;
                endcase
            end
        end
    end

    assign init_done = (state_q == READY);

    // Stored ICWs, mask and read-select; ICW1 restarts the whole initialisation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icw1_q <= 8'h00;
            icw2_q <= 8'h00;
            icw3_q <= 8'h00;
            icw4_q <= 8'h00;
            imr    <= RESET_IMR;
            ris    <= 1'b0;
        end else begin
            if (ld_icw1) begin
                icw1_q <= s_din;
                icw3_q <= 8'h00;
                icw4_q <= 8'h00;
                imr    <= RESET_IMR;
                ris    <= 1'b0;
            end
            if (ld_icw2) icw2_q <= s_din;
            if (ld_icw3) icw3_q <= s_din;
            if (ld_icw4) icw4_q <= s_din;
            if (ld_imr)  imr    <= s_din;
            if (ld_ris)  ris    <= s_din[0];
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = ~fifo_empty & cmd_ready;
    assign push_ok    = accept & (~fifo_full | pop);
    assign ovf_d      = accept & fifo_full & ~pop;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {push_type, push_nr, s_din};
        end
    end

    // FIFO pointers plus the one-cycle error and overflow pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            seq_err  <= 1'b0;
            fifo_ovf <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            seq_err  <= err_d;
            fifo_ovf <= ovf_d;
        end
    end

    assign cmd_valid = ~fifo_empty;
    assign {cmd_type, cmd_nr, cmd_data} = cmd_valid ? fifo_mem[rd_ptr[AW-1:0]] : 11'd0;

    assign doe_d = ~s_cs_n & ~s_rd_n & s_wr_n;

    // Registered CPU read mux: mask on a0=1, otherwise ISR or IRR by read-select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_doe  <= 1'b0;
            cpu_dout <= 8'h00;
        end else begin
            cpu_doe <= doe_d;
            if (doe_d) cpu_dout <= s_a0 ? imr : (ris ? isr_in : irr_in);
            else       cpu_dout <= 8'h00;
        end
    end

endmodule
